rv32i_lsu: RTL and testbench

Load/store unit that sits between the rv32i core's execute stage and the data-bus memory (`memory`/`rv32i_mem_ctrl`). It is the initiator end of the bus: it accepts one load or store request from the core, drives `baddr`/`bsz`/`bdi`/`bwr`, waits for `mrdy`, and returns sign- or zero-extended load data. It also reports misaligned, illegal-size and timed-out accesses as errors.

---
 rtl/rv32i_lsu_if.sv | 30 +++
 rtl/rv32i_lsu.sv | 131 +++++++++++++
 tb/tb_rv32i_lsu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_lsu_if.sv
// Core-side request/response and initiator data-bus signals of the LSU.
// master = the LSU itself, slave = the core plus memory responder driving it.
interface rv32i_lsu_if;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        breq;
   logic [31:0] baddr;
   logic [1:0]  bsz;
   logic [31:0] bdi;
   logic        bwr;
   logic [31:0] bdo;
   logic        mrdy;

   modport master (
      input  req, we, funct3, addr, wdata, bdo, mrdy,
      output busy, ack, err, rdata, breq, baddr, bsz, bdi, bwr
   );

   modport slave (
      output req, we, funct3, addr, wdata, bdo, mrdy,
      input  busy, ack, err, rdata, breq, baddr, bsz, bdi, bwr
   );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time, ack 2 cycles after req plus one per wait state.
// No queueing: req is only sampled in IDLE; mrdy stalls ACCESS until TIMEOUT aborts it.
module rv32i_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   rv32i_lsu_if.master bus
);
   localparam logic [7:0] LP_TO = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_busy;
   logic        r_ack;
   logic        r_err;
   logic        r_breq;
   logic        r_bwr;
   logic [31:0] r_rdata;
   logic [31:0] r_baddr;
   logic [31:0] r_bdi;
   logic [1:0]  r_bsz;
   logic [2:0]  r_f3;
   logic [7:0]  r_cnt;

   logic        w_illegal;
   logic        w_misalign;
   logic [31:0] w_bdi;
   logic [31:0] w_ext;

   always_comb begin
      // funct3[1:0] doubles as the bus size code; 11 never names a legal width
      w_illegal  = (bus.funct3[1:0] == 2'b11) ||
                   (bus.we && bus.funct3[2]) ||
                   (!bus.we && bus.funct3 == 3'b110);
      w_misalign = (bus.funct3[1:0] == 2'b01 && bus.addr[0]) ||
                   (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
      case (bus.funct3[1:0])
         2'b00:   w_bdi = {24'b0, bus.wdata[7:0]};
         2'b01:   w_bdi = {16'b0, bus.wdata[15:0]};
         default: w_bdi = bus.wdata;
      endcase
      case (r_f3)
         3'b000:  w_ext = {{24{bus.bdo[7]}}, bus.bdo[7:0]};
         3'b001:  w_ext = {{16{bus.bdo[15]}}, bus.bdo[15:0]};
         3'b100:  w_ext = {24'b0, bus.bdo[7:0]};
         3'b101:  w_ext = {16'b0, bus.bdo[15:0]};
         default: w_ext = bus.bdo;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_breq  <= 1'b0;
         r_bwr   <= 1'b0;
         r_rdata <= '0;
         r_baddr <= '0;
         r_bdi   <= '0;
         r_bsz   <= 2'b00;
         r_f3    <= 3'b000;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_busy <= 1'b1;
                  if (w_illegal || w_misalign) begin
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                     r_ack   <= 1'b1;
                     r_state <= S_RESP;
                  end else begin
                     r_baddr <= bus.addr;
                     r_bsz   <= bus.funct3[1:0];
                     r_bdi   <= w_bdi;
                     r_bwr   <= bus.we;
                     r_f3    <= bus.funct3;
                     r_breq  <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (bus.mrdy) begin
                  r_err   <= 1'b0;
                  r_rdata <= r_bwr ? 32'd0 : w_ext;
                  r_breq  <= 1'b0;
                  r_bwr   <= 1'b0;
                  r_ack   <= 1'b1;
                  r_state <= S_RESP;
               end else if (r_cnt == LP_TO) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  r_breq  <= 1'b0;
                  r_bwr   <= 1'b0;
                  r_ack   <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.ack   = r_ack;
   assign bus.err   = r_err;
   assign bus.rdata = r_rdata;
   assign bus.breq  = r_breq;
   assign bus.baddr = r_baddr;
   assign bus.bsz   = r_bsz;
   assign bus.bdi   = r_bdi;
   assign bus.bwr   = r_bwr;
endmodule

// File: tb/tb_rv32i_lsu.sv
// Randomised bench for rv32i_lsu: a byte-array responder serves the bus and a
// separate byte-array reference memory predicts every response from RV32I rules.
module tb_rv32i_lsu;
   localparam int TO = 4;

   logic clk;
   logic rst_n;
   rv32i_lsu_if bus_if();

   rv32i_lsu #(.TIMEOUT(TO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   logic [7:0]  rmem [256];
   logic [7:0]  mmem [256];
   logic [31:0] last_rdata;
   logic        last_err;

   // Responder read: addressed bytes right-aligned, the rest garbage.
   function automatic logic [31:0] resp_data(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] v;
      v = $urandom;
      v[7:0] = rmem[a[7:0]];
      if (sz != 2'b00) v[15:8] = rmem[8'(a[7:0] + 8'd1)];
      if (sz == 2'b10) begin
         v[23:16] = rmem[8'(a[7:0] + 8'd2)];
         v[31:24] = rmem[8'(a[7:0] + 8'd3)];
      end
      return v;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input int nbytes, input bit sgn);
      longint v;
      v = 0;
      for (int i = 0; i < nbytes; i++)
         v = v + (longint'(mmem[8'(a[7:0] + 8'(i))]) << (8 * i));
      if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
         v = v - (longint'(1) << (8 * nbytes));
      return v[31:0];
   endfunction

   task automatic idle_inputs();
      bus_if.req    = 1'b0;
      bus_if.we     = 1'b0;
      bus_if.funct3 = 3'b000;
      bus_if.addr   = '0;
      bus_if.wdata  = '0;
      bus_if.bdo    = '0;
      bus_if.mrdy   = 1'b0;
   endtask

   task automatic do_txn(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input int t_w);
      int          sz, nbytes, exp_lat, exp_nacc, nacc;
      bit          illegal, mis, valid, tmo, got_ack;
      logic [31:0] exp_bdi, exp_rdata;
      logic        exp_err;
      sz      = int'(t_f3[1:0]);
      illegal = (sz == 3) || (t_we && t_f3[2]) || (!t_we && t_f3 == 3'b110);
      nbytes  = 1 << sz;
      mis     = (nbytes == 2 && t_addr % 2 != 0) || (nbytes == 4 && t_addr % 4 != 0);
      valid   = !illegal && !mis;
      tmo     = valid && t_w > TO;
      exp_err = !valid || tmo;
      exp_bdi = (nbytes >= 4) ? t_wdata : 32'(64'(t_wdata) % (64'd1 << (8 * nbytes)));
      exp_rdata = (exp_err || t_we) ? 32'd0 : model_load(t_addr, nbytes, !t_f3[2]);
      exp_lat  = !valid ? 1 : (tmo ? TO + 2 : t_w + 2);
      exp_nacc = !valid ? 0 : (tmo ? TO + 1 : t_w + 1);
      if (valid && t_we && !tmo)
         for (int i = 0; i < nbytes; i++)
            mmem[8'(t_addr[7:0] + 8'(i))] = t_wdata[8 * i +: 8];

      @(negedge clk);
      bus_if.req    = 1'b1;
      bus_if.we     = t_we;
      bus_if.funct3 = t_f3;
      bus_if.addr   = t_addr;
      bus_if.wdata  = t_wdata;
      bus_if.mrdy   = 1'b0;
      bus_if.bdo    = $urandom;
      got_ack = 0;
      nacc    = 0;
      for (int cyc = 1; cyc <= 30 && !got_ack; cyc++) begin
         @(negedge clk);
         bus_if.req  = 1'b0;
         bus_if.mrdy = 1'b0;
         nvec++;
         if (bus_if.busy !== 1'b1) begin
            nerr++;
            $display("FAIL busy cyc=%0d got=%b want=1", cyc, bus_if.busy);
         end
         if (bus_if.breq === 1'b1) begin
            nvec++;
            if ({bus_if.baddr, bus_if.bsz, bus_if.bdi, bus_if.bwr} !== {t_addr, 2'(sz), exp_bdi, t_we}) begin
               nerr++;
               $display("FAIL bus cyc=%0d got addr=%h sz=%0d bdi=%h wr=%b want addr=%h sz=%0d bdi=%h wr=%b",
                        cyc, bus_if.baddr, bus_if.bsz, bus_if.bdi, bus_if.bwr, t_addr, sz, exp_bdi, t_we);
            end
            if (nacc == t_w) begin
               bus_if.mrdy = 1'b1;
               if (bus_if.bwr === 1'b1)
                  for (int i = 0; i < (1 << bus_if.bsz); i++)
                     rmem[8'(bus_if.baddr[7:0] + 8'(i))] = bus_if.bdi[8 * i +: 8];
            end
            bus_if.bdo = resp_data(bus_if.baddr, bus_if.bsz);
            nacc++;
         end
         if (bus_if.ack === 1'b1) begin
            got_ack    = 1;
            last_rdata = bus_if.rdata;
            last_err   = bus_if.err;
            nvec += 3;
            if (cyc != exp_lat) begin
               nerr++;
               $display("FAIL ack_latency got=%0d want=%0d", cyc, exp_lat);
            end
            if ({bus_if.err, bus_if.rdata} !== {exp_err, exp_rdata}) begin
               nerr++;
               $display("FAIL response got err=%b rdata=%h want err=%b rdata=%h",
                        bus_if.err, bus_if.rdata, exp_err, exp_rdata);
            end
            if (nacc != exp_nacc) begin
               nerr++;
               $display("FAIL access_cycles got=%0d want=%0d", nacc, exp_nacc);
            end
         end
      end
      if (!got_ack) begin
         nvec++;
         nerr++;
         $display("FAIL no_ack within 30 cycles (we=%b f3=%b addr=%h)", t_we, t_f3, t_addr);
      end
   endtask

   task automatic check_reset_values(input string tag);
      nvec++;
      if ({bus_if.busy, bus_if.ack, bus_if.err, bus_if.breq, bus_if.bwr,
           bus_if.rdata, bus_if.baddr, bus_if.bdi, bus_if.bsz} !== '0) begin
         nerr++;
         $display("FAIL %s got busy=%b ack=%b err=%b breq=%b bwr=%b rdata=%h baddr=%h bdi=%h bsz=%b want all 0",
                  tag, bus_if.busy, bus_if.ack, bus_if.err, bus_if.breq, bus_if.bwr,
                  bus_if.rdata, bus_if.baddr, bus_if.bdi, bus_if.bsz);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset_values");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("idle_after_reset");
   endtask

   task automatic test_directed_loads_stores();
      rmem[8'h01] = 8'h80;
      mmem[8'h01] = 8'h80;
      do_txn(1'b0, 3'b000, 32'h0000_0101, $urandom, 0);
      nvec++;
      if (last_rdata !== 32'hFFFF_FF80) begin
         nerr++; $display("FAIL lb_sign got=%h want=ffffff80", last_rdata);
      end
      do_txn(1'b0, 3'b100, 32'h0000_0101, $urandom, 0);
      nvec++;
      if (last_rdata !== 32'h0000_0080) begin
         nerr++; $display("FAIL lbu_zero got=%h want=00000080", last_rdata);
      end
      do_txn(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 0);
      do_txn(1'b0, 3'b001, 32'h0000_0202, $urandom, 0);
      nvec++;
      if (last_rdata !== 32'hFFFF_BEEF) begin
         nerr++; $display("FAIL sh_lh_readback got=%h want=ffffbeef", last_rdata);
      end
   endtask

   task automatic test_errors();
      do_txn(1'b0, 3'b010, 32'h0000_0103, $urandom, 0);
      do_txn(1'b0, 3'b011, 32'h0000_0100, $urandom, 0);
      do_txn(1'b1, 3'b100, 32'h0000_0100, $urandom, 0);
      nvec++;
      if (last_err !== 1'b1 || last_rdata !== 32'd0) begin
         nerr++; $display("FAIL illegal_store got err=%b rdata=%h want err=1 rdata=0", last_err, last_rdata);
      end
   endtask

   task automatic test_wait_and_timeout();
      rmem[8'h10] = 8'h78; rmem[8'h11] = 8'h56; rmem[8'h12] = 8'h34; rmem[8'h13] = 8'h12;
      mmem[8'h10] = 8'h78; mmem[8'h11] = 8'h56; mmem[8'h12] = 8'h34; mmem[8'h13] = 8'h12;
      do_txn(1'b0, 3'b010, 32'h0000_0010, $urandom, 3);
      nvec++;
      if (last_rdata !== 32'h1234_5678) begin
         nerr++; $display("FAIL wait_lw got=%h want=12345678", last_rdata);
      end
      do_txn(1'b0, 3'b010, 32'h0000_0020, $urandom, TO);
      do_txn(1'b0, 3'b010, 32'h0000_0020, $urandom, 20);
      do_txn(1'b1, 3'b000, 32'h0000_0021, $urandom, 20);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [2:0]  f3;
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 6));
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.funct3 = 3'b010;
      bus_if.addr = 32'h0000_0080; bus_if.wdata = 32'hCAFE_F00D; bus_if.mrdy = 1'b0;
      @(negedge clk);
      bus_if.req = 1'b0;
      nvec++;
      if (bus_if.breq !== 1'b1 || bus_if.bwr !== 1'b1) begin
         nerr++; $display("FAIL store_started got breq=%b bwr=%b want 1 1", bus_if.breq, bus_if.bwr);
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_values("async_reset_mid_access");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nvec++;
         if (bus_if.ack !== 1'b0 || bus_if.breq !== 1'b0) begin
            nerr++; $display("FAIL no_ack_in_reset got ack=%b breq=%b want 0 0", bus_if.ack, bus_if.breq);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("idle_after_abort");
      do_txn(1'b0, 3'b010, 32'h0000_0080, $urandom, 1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_word;
      bit          w_breq, w_ack, w_busy;
      exp_word = model_load(32'h0000_0040, 4, 1'b0);
      @(negedge clk);
      bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = 3'b010;
      bus_if.addr = 32'h0000_0040; bus_if.mrdy = 1'b1;
      bus_if.bdo = resp_data(32'h0000_0040, 2'b10);
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         // accepted every third cycle: ACCESS, RESP, then one IDLE cycle
         w_breq = ((t - 1) % 3 == 0);
         w_ack  = ((t - 1) % 3 == 1);
         w_busy = ((t - 1) % 3 != 2);
         nvec++;
         if ({bus_if.breq, bus_if.ack, bus_if.busy} !== {w_breq, w_ack, w_busy}) begin
            nerr++;
            $display("FAIL b2b cyc=%0d got breq=%b ack=%b busy=%b want %b %b %b",
                     t, bus_if.breq, bus_if.ack, bus_if.busy, w_breq, w_ack, w_busy);
         end
         if (w_ack) begin
            nvec++;
            if (bus_if.rdata !== exp_word || bus_if.err !== 1'b0) begin
               nerr++; $display("FAIL b2b_data cyc=%0d got=%h err=%b want=%h err=0", t, bus_if.rdata, bus_if.err, exp_word);
            end
         end
      end
      idle_inputs();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rmem[i] = 8'($urandom);
         mmem[i] = rmem[i];
      end
      last_rdata = '0;
      last_err   = 1'b0;
      test_reset();
      test_directed_loads_stores();
      test_errors();
      test_wait_and_timeout();
      test_random();
      test_reset_mid_access();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
